// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with write-port bypass and a busy-bit
// scoreboard for long-latency results. Port 0 carries single-cycle writeback,
// port 1 carries long-latency writeback and clears the destination busy bit.
module regfile_sb #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int AW       = 5,
    parameter int NR       = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NR*AW-1:0]     rd_addr,
    input  logic [NR-1:0]        rd_en,
    output logic [NR*XLEN-1:0]   rd_data,
    input  logic                 we0,
    input  logic [AW-1:0]        wa0,
    input  logic [XLEN-1:0]      wd0,
    input  logic                 we1,
    input  logic [AW-1:0]        wa1,
    input  logic [XLEN-1:0]      wd1,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_rd,
    input  logic                 iss_rd_en,
    input  logic                 iss_long,
    input  logic                 flush,
    output logic                 stall,
    output logic [NREGS-1:0]     sb_busy,
    output logic                 conflict_err
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] eb;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] busy_nxt;
    logic             conflict_q;
    logic             drop0;
    logic             drop1;
    logic             set_en;
    logic             src_hit;
    logic             waw_hit;

    assign sb_busy      = busy;
    assign conflict_err = conflict_q;

    // Register 0 writes are discarded when it is the hardwired zero register.
    assign drop0 = (ZERO_REG != 0) && (wa0 == '0);
    assign drop1 = (ZERO_REG != 0) && (wa1 == '0);

    // Combinational read with bypass: zero reg, then port 0, then port 1, then array.
    always_comb begin
        logic [AW-1:0] a;
        a       = '0;
        rd_data = '0;
        for (int k = 0; k < NR; k++) begin
            a = rd_addr[k*AW +: AW];
            if ((ZERO_REG != 0) && (a == '0))
                rd_data[k*XLEN +: XLEN] = '0;
            else if (we0 && (wa0 == a))
                rd_data[k*XLEN +: XLEN] = wd0;
            else if (we1 && (wa1 == a))
                rd_data[k*XLEN +: XLEN] = wd1;
            else
                rd_data[k*XLEN +: XLEN] = regs[a];
        end
    end

    // Effective busy: a long result landing this cycle is bypassed, so it is not a hazard.
    always_comb begin
        clr_mask = '0;
        if (we1)
            clr_mask[wa1] = 1'b1;
        eb = busy & ~clr_mask;
        if (ZERO_REG != 0)
            eb[0] = 1'b0;
    end

    // Hazard detection for source operands (RAW) and destination (WAW).
    always_comb begin
        src_hit = 1'b0;
        for (int k = 0; k < NR; k++) begin
            if (rd_en[k] && eb[rd_addr[k*AW +: AW]])
                src_hit = 1'b1;
        end
        waw_hit = iss_rd_en && eb[iss_rd];
        stall   = iss_valid && (src_hit || waw_hit);
    end

    // Next busy state: flush beats everything, a set beats a same-cycle clear.
    always_comb begin
        set_en   = iss_valid && !stall && iss_rd_en && iss_long &&
                   !((ZERO_REG != 0) && (iss_rd == '0));
        set_mask = '0;
        if (set_en)
            set_mask[iss_rd] = 1'b1;
        if (flush)
            busy_nxt = '0;
        else
            busy_nxt = (busy & ~clr_mask) | set_mask;
    end

    // Scoreboard and sticky conflict flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= '0;
            conflict_q <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (we0 && we1 && (wa0 == wa1) && !drop0)
                conflict_q <= 1'b1;
        end
    end

    // Register array; port 0 is applied last so it wins a same-register collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++)
                regs[r] <= '0;
        end else begin
            if (we1 && !drop1)
                regs[wa1] <= wd1;
            if (we0 && !drop0)
                regs[wa0] <= wd0;
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: integer-file instance (ZERO_REG=1, NR=2)
// and FP-file instance (ZERO_REG=0, NR=3) sharing clock and reset.
module tb_regfile_sb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // integer-file instance signals
    logic [9:0]  i_rd_addr;
    logic [1:0]  i_rd_en;
    logic [63:0] i_rd_data;
    logic        i_we0, i_we1;
    logic [4:0]  i_wa0, i_wa1;
    logic [31:0] i_wd0, i_wd1;
    logic        i_iss_valid, i_iss_rd_en, i_iss_long, i_flush;
    logic [4:0]  i_iss_rd;
    logic        i_stall, i_conflict;
    logic [31:0] i_busy;

    // FP-file instance signals
    logic [14:0] f_rd_addr;
    logic [2:0]  f_rd_en;
    logic [95:0] f_rd_data;
    logic        f_we0, f_we1;
    logic [4:0]  f_wa0, f_wa1;
    logic [31:0] f_wd0, f_wd1;
    logic        f_iss_valid, f_iss_rd_en, f_iss_long, f_flush;
    logic [4:0]  f_iss_rd;
    logic        f_stall, f_conflict;
    logic [31:0] f_busy;

    regfile_sb u_int (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(i_rd_addr), .rd_en(i_rd_en), .rd_data(i_rd_data),
        .we0(i_we0), .wa0(i_wa0), .wd0(i_wd0),
        .we1(i_we1), .wa1(i_wa1), .wd1(i_wd1),
        .iss_valid(i_iss_valid), .iss_rd(i_iss_rd), .iss_rd_en(i_iss_rd_en),
        .iss_long(i_iss_long), .flush(i_flush),
        .stall(i_stall), .sb_busy(i_busy), .conflict_err(i_conflict)
    );

    regfile_sb #(.NR(3), .ZERO_REG(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(f_rd_addr), .rd_en(f_rd_en), .rd_data(f_rd_data),
        .we0(f_we0), .wa0(f_wa0), .wd0(f_wd0),
        .we1(f_we1), .wa1(f_wa1), .wd1(f_wd1),
        .iss_valid(f_iss_valid), .iss_rd(f_iss_rd), .iss_rd_en(f_iss_rd_en),
        .iss_long(f_iss_long), .flush(f_flush),
        .stall(f_stall), .sb_busy(f_busy), .conflict_err(f_conflict)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_int();
        i_rd_en = '0; i_we0 = 0; i_we1 = 0; i_iss_valid = 0;
        i_iss_rd_en = 0; i_iss_long = 0; i_flush = 0;
    endtask

    task automatic idle_fp();
        f_rd_en = '0; f_we0 = 0; f_we1 = 0; f_iss_valid = 0;
        f_iss_rd_en = 0; f_iss_long = 0; f_flush = 0;
    endtask

    // one-cycle long-latency issue on the integer file
    task automatic issue_long_int(input logic [4:0] rd);
        i_iss_valid = 1; i_iss_rd = rd; i_iss_rd_en = 1; i_iss_long = 1;
        step();
        idle_int();
    endtask

    initial begin
        logic [4:0] av;
        rst_n = 0;
        i_rd_addr = '0; i_wa0 = '0; i_wa1 = '0; i_wd0 = '0; i_wd1 = '0; i_iss_rd = '0;
        f_rd_addr = '0; f_wa0 = '0; f_wa1 = '0; f_wd0 = '0; f_wd1 = '0; f_iss_rd = '0;
        idle_int();
        idle_fp();
        #1;
        chk("rst_busy", i_busy, 0);
        chk("rst_conflict", i_conflict, 0);
        chk("rst_stall", i_stall, 0);
        step();
        step();
        rst_n = 1;
        #1;

        // all registers read zero after reset, both ports
        for (int a = 0; a < 32; a++) begin
            av = a[4:0];
            i_rd_addr = {av, av};
            #1;
            chk("rst_rd", i_rd_data, 0);
        end

        // writes to register 0 are discarded, bypass included
        i_rd_addr = 10'd0;
        i_we0 = 1; i_wa0 = 5'd0; i_wd0 = 32'hDEADBEEF;
        #1;
        chk("r0_bypass", i_rd_data[31:0], 0);
        step();
        i_we0 = 0;
        #1;
        chk("r0_stored", i_rd_data[31:0], 0);

        // port 0 bypass and storage
        i_rd_addr[4:0] = 5'd5;
        i_we0 = 1; i_wa0 = 5'd5; i_wd0 = 32'h12345678;
        #1;
        chk("wb0_bypass", i_rd_data[31:0], 32'h12345678);
        step();
        i_we0 = 0;
        #1;
        chk("wb0_stored", i_rd_data[31:0], 32'h12345678);

        // long issue to r7 sets busy next cycle
        i_iss_valid = 1; i_iss_rd = 5'd7; i_iss_rd_en = 1; i_iss_long = 1;
        #1;
        chk("iss7_stall", i_stall, 0);
        step();
        idle_int();
        chk("busy7_set", i_busy, 32'h0000_0080);

        // RAW on r7
        i_iss_valid = 1; i_iss_rd = 5'd8; i_rd_addr[4:0] = 5'd7; i_rd_en = 2'b01;
        #1;
        chk("raw7_stall", i_stall, 1);
        // RAW on port 1 only
        i_rd_addr = {5'd7, 5'd1}; i_rd_en = 2'b10;
        #1;
        chk("raw7_p1_stall", i_stall, 1);
        // WAW on r7
        i_rd_en = 2'b00; i_iss_rd = 5'd7; i_iss_rd_en = 1;
        #1;
        chk("waw7_stall", i_stall, 1);
        // rd_en low: busy source does not stall
        i_iss_rd = 5'd8; i_iss_rd_en = 0; i_rd_addr = {5'd1, 5'd7};
        #1;
        chk("rd_en_low", i_stall, 0);
        // completion on port 1 in the same cycle removes the hazard
        i_rd_en = 2'b01;
        i_we1 = 1; i_wa1 = 5'd7; i_wd1 = 32'hCAFE0001;
        #1;
        chk("cmpl7_stall", i_stall, 0);
        chk("cmpl7_bypass", i_rd_data[31:0], 32'hCAFE0001);
        step();
        idle_int();
        chk("busy7_clr", i_busy, 0);
        chk("r7_stored", i_rd_data[31:0], 32'hCAFE0001);

        // long issue to r0 never marks busy; short issue never marks busy
        issue_long_int(5'd0);
        chk("busy_r0", i_busy, 0);
        i_iss_valid = 1; i_iss_rd = 5'd6; i_iss_rd_en = 1; i_iss_long = 0;
        step();
        idle_int();
        chk("busy_short", i_busy, 0);

        // busy r3, then a stalled long issue must not set its destination
        issue_long_int(5'd3);
        chk("busy3_set", i_busy, 32'h0000_0008);
        i_iss_valid = 1; i_iss_rd = 5'd10; i_iss_rd_en = 1; i_iss_long = 1;
        i_rd_addr = {5'd3, 5'd0}; i_rd_en = 2'b10;
        #1;
        chk("raw3_stall", i_stall, 1);
        step();
        idle_int();
        chk("stalled_noset", i_busy, 32'h0000_0008);

        // clear and set of r3 in the same cycle: set wins
        i_we1 = 1; i_wa1 = 5'd3; i_wd1 = 32'h0000_0033;
        i_iss_valid = 1; i_iss_rd = 5'd3; i_iss_rd_en = 1; i_iss_long = 1;
        #1;
        chk("setclr3_stall", i_stall, 0);
        step();
        idle_int();
        chk("setclr3_busy", i_busy, 32'h0000_0008);

        // simultaneous write of r0 on both ports is dropped: no conflict
        i_we0 = 1; i_wa0 = 5'd0; i_wd0 = 32'h1;
        i_we1 = 1; i_wa1 = 5'd0; i_wd1 = 32'h2;
        step();
        idle_int();
        chk("r0_noconflict", i_conflict, 0);

        // write-port conflict on r9: port 0 wins, flag is sticky
        i_rd_addr[4:0] = 5'd9;
        i_we0 = 1; i_wa0 = 5'd9; i_wd0 = 32'h1;
        i_we1 = 1; i_wa1 = 5'd9; i_wd1 = 32'h2;
        #1;
        chk("conf_bypass", i_rd_data[31:0], 32'h1);
        step();
        idle_int();
        chk("conf_r9", i_rd_data[31:0], 32'h1);
        chk("conf_set", i_conflict, 1);
        step();
        step();
        chk("conf_sticky", i_conflict, 1);

        // asynchronous reset mid-run clears everything immediately
        #2;
        rst_n = 0;
        #1;
        chk("arst_conflict", i_conflict, 0);
        chk("arst_busy", i_busy, 0);
        chk("arst_r9", i_rd_data[31:0], 0);
        step();
        rst_n = 1;
        #1;

        // flush clears all busy bits and overrides a same-cycle set
        issue_long_int(5'd1);
        issue_long_int(5'd2);
        issue_long_int(5'd4);
        chk("busy_124", i_busy, 32'h0000_0016);
        i_flush = 1;
        i_iss_valid = 1; i_iss_rd = 5'd5; i_iss_rd_en = 1; i_iss_long = 1;
        step();
        idle_int();
        chk("flush_busy", i_busy, 0);
        // late long result after flush still writes, no error, busy stays clear
        i_rd_addr[4:0] = 5'd2;
        i_we1 = 1; i_wa1 = 5'd2; i_wd1 = 32'h0000_00AA;
        step();
        idle_int();
        chk("late_r2", i_rd_data[31:0], 32'h0000_00AA);
        chk("late_conflict", i_conflict, 0);
        chk("late_busy", i_busy, 0);

        // FP file: register 0 is ordinary and can be busy
        f_we0 = 1; f_wa0 = 5'd0; f_wd0 = 32'h0000_0055;
        step();
        idle_fp();
        f_rd_addr = {5'd0, 5'd1, 5'd2};
        #1;
        chk("fp_r0_wr", f_rd_data[95:64], 32'h0000_0055);
        f_iss_valid = 1; f_iss_rd = 5'd0; f_iss_rd_en = 1; f_iss_long = 1;
        step();
        idle_fp();
        chk("fp_busy0", f_busy, 32'h0000_0001);
        f_iss_valid = 1; f_iss_rd = 5'd12; f_rd_en = 3'b100;
        #1;
        chk("fp_rs3_stall", f_stall, 1);
        f_we1 = 1; f_wa1 = 5'd0; f_wd1 = 32'h3F80_0000;
        #1;
        chk("fp_cmpl_stall", f_stall, 0);
        chk("fp_cmpl_bypass", f_rd_data[95:64], 32'h3F80_0000);
        step();
        idle_fp();
        chk("fp_busy_clr", f_busy, 0);
        chk("fp_r0_long", f_rd_data[95:64], 32'h3F80_0000);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // guard against a runaway run
    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised multi-port register file with an integrated scoreboard for the RV32ICMFA pipeline.
- One instance serves as the integer file (ZERO_REG=1). A second serves as the FP file (ZERO_REG=0, NR=3 so FMA can read rs3).
- Write port 0 carries single-cycle writeback. Write port 1 carries long-latency results from the M/F/A units.
- Busy bits track pending long-latency destinations and raise a stall for RAW/WAW hazards at issue.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of registers (power of two, ≥2)
AW, 5, address width, equal to log2(NREGS)
NR, 2, number of read ports (1..4)
ZERO_REG, 1, 1: register 0 is hardwired to zero and is never busy; 0: register 0 is an ordinary register

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
rd_addr  in  NR*AW  read addresses; port k occupies bits [k*AW +: AW]
rd_en  in  NR  read port k is a real source operand (used for hazard detection only)
rd_data  out  NR*XLEN  read data; port k occupies bits [k*XLEN +: XLEN]
we0, wa0, wd0  in  1/AW/XLEN  single-cycle writeback port
we1, wa1, wd1  in  1/AW/XLEN  long-latency writeback port; also clears busy[wa1]
iss_valid  in  1  instruction presented at issue
iss_rd  in  AW  destination register of the issuing instruction
iss_rd_en  in  1  issuing instruction writes iss_rd
iss_long  in  1  issuing instruction completes through port 1
flush  in  1  synchronous clear of all busy bits
stall  out  1  issue hazard (combinational)
sb_busy  out  NREGS  busy vector (registered)
conflict_err  out  1  sticky: both write ports wrote the same register in the same cycle

Behaviour:
- Reset (asynchronous): all registers = 0, sb_busy = 0, conflict_err = 0. stall then depends only on the current inputs.
- Reads are combinational, with 0-cycle latency.
- Read bypass priority per port k:
  - ZERO_REG=1 and address 0 → 0.
  - else we0 && wa0==addr → wd0.
  - else we1 && wa1==addr → wd1.
  - else the array value.
- Writes occur at posedge clk.
  - A write to register 0 is dropped when ZERO_REG=1.
  - If we0 && we1 && wa0==wa1 (and the write is not dropped): wd0 is stored, and conflict_err sets and holds until reset.
- Effective busy: eb[r] = sb_busy[r] && !(we1 && wa1==r). A result completing this cycle is bypassed, so it does not stall.
- stall = iss_valid && (SRC || WAW).
  - SRC = OR over k of (rd_en[k] && eb[rd_addr[k]]).
  - WAW = iss_rd_en && eb[iss_rd].
  - When ZERO_REG=1, register 0 never contributes to SRC or WAW.
- Accepted issue = iss_valid && !stall.
- Busy update at posedge, evaluated in this order:
  1. flush → all busy bits = 0. flush overrides any set or clear in the same cycle.
  2. Clear: we1 → busy[wa1] = 0.
  3. Set: accepted issue && iss_rd_en && iss_long → busy[iss_rd] = 1. Set wins over a clear of the same register in the same cycle.
  4. No set when ZERO_REG=1 and iss_rd==0.
- we0 does not affect busy.
- A we1 to a non-busy register (for example after a flush) still writes the array, does not flag an error, and leaves busy at 0.
- Short-latency issues (iss_long=0) never set busy. The pipeline owns their forwarding.
- An asynchronous reset mid-operation clears everything immediately; any in-flight long result arriving later writes normally.
- sb_busy reflects the registered state, so it changes the cycle after a set or clear.

Test Plan:
- Reset, then read all addresses on every port → all 0. Set we0, wa0=0, wd0=0xDEADBEEF (ZERO_REG=1), then read register 0 → 0.
- Write reg 5 = 0x12345678 via port 0, reading rd_addr=5 in the same cycle → rd_data = 0x12345678. Next cycle, with we0=0 → still 0x12345678.
- Issue iss_rd=7 with iss_long=1 → sb_busy[7]=1 the next cycle.
  - Then issue with rd_addr[0]=7, rd_en[0]=1 → stall=1.
  - Drive we1, wa1=7, wd1=0xCAFE0001 in the same cycle → stall=0, rd_data = 0xCAFE0001, and sb_busy[7]=0 the next cycle.
- With busy[3]=1, in one cycle drive we1 to reg 3 and issue a long-latency op to iss_rd=3 → the issue is accepted (stall=0) and sb_busy[3] remains 1.
- In one cycle drive we0 (reg 9, 0x1) and we1 (reg 9, 0x2) → reg 9 reads 0x1 and conflict_err=1, which persists until rst_n is asserted.
- Set busy on regs 1, 2 and 4, then assert flush → sb_busy=0 the next cycle.
  - A later we1 to reg 2 with 0xAA stores 0xAA, conflict_err stays 0, and sb_busy stays 0.
  - Repeat with ZERO_REG=0, NR=3: reg 0 is writable and can become busy.
